// File: rtl/add_tc_pkg.sv
// add_tc_pkg: shared constants for the pipelined
// carry-lookahead adder/subtractor.
package add_tc_pkg;

  localparam int GRP = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam logic MODE_UNS = 1'b0;
  localparam logic MODE_SGN = 1'b1;

endpackage

// File: rtl/add_tc_pipe_if.sv
// add_tc_pipe_if: operand/result valid-ready bundle
// for the pipelined adder/subtractor.
interface add_tc_pipe_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             op_sub;
  logic             op_signed;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   result;
  logic             overflow;

  modport master (
    output in_valid, a, b, op_sub, op_signed, out_ready,
    input  in_ready, out_valid, result, overflow
  );

  modport slave (
    input  in_valid, a, b, op_sub, op_signed, out_ready,
    output in_ready, out_valid, result, overflow
  );

endinterface

// File: rtl/cla_add_n.sv
// cla_add_n: N-bit two-level carry-lookahead adder
// built from GRP-bit lookahead groups.
module cla_add_n
  import add_tc_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         cmsb
);

  localparam int NG = N / GRP;

  logic [N-1:0]  p;
  logic [N-1:0]  g;
  logic [NG-1:0] gp;
  logic [NG-1:0] gg;
  logic [NG:0]   gc;
  logic [N:0]    c;

  assign p = a ^ b;
  assign g = a & b;

  always_comb begin
    logic acc;
    logic pr;
    gp = '0;
    gg = '0;
    gc = '0;
    c  = '0;
    acc = 1'b0;
    pr  = 1'b1;
    for (int k = 0; k < NG; k++) begin
      gp[k] = &p[k*GRP +: GRP];
      for (int i = 0; i < GRP; i++)
        gg[k] = g[k*GRP+i] | (p[k*GRP+i] & gg[k]);
    end
    // second level: each group carry straight from cin
    gc[0] = cin;
    for (int k = 0; k < NG; k++) begin
      acc = 1'b0;
      pr  = 1'b1;
      for (int j = k; j >= 0; j--) begin
        acc = acc | (pr & gg[j]);
        pr  = pr & gp[j];
      end
      gc[k+1] = acc | (pr & cin);
    end
    for (int k = 0; k < NG; k++) begin
      c[k*GRP] = gc[k];
      for (int i = 1; i < GRP; i++)
        c[k*GRP+i] = g[k*GRP+i-1] |
                     (p[k*GRP+i-1] & c[k*GRP+i-1]);
    end
    c[N] = gc[NG];
  end

  assign s    = p ^ c[N-1:0];
  assign cout = c[N];
  assign cmsb = c[N-1];

endmodule

// File: rtl/add_tc_pipe.sv
// add_tc_pipe: 2-stage pipelined CLA add/sub with
// signed/unsigned modes, overflow and valid/ready.
module add_tc_pipe
  import add_tc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int HALF  = WIDTH / 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op_sub,
  input  logic             op_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   result,
  output logic             overflow
);

  logic adv1;
  logic adv2;

  logic [WIDTH-1:0] b_eff;
  logic [HALF-1:0]  lo_s;
  logic             lo_c;
  logic             unused_lo_cmsb;

  logic            s1_valid;
  logic [HALF-1:0] s1_lo;
  logic            s1_c;
  logic [HALF-1:0] s1_a;
  logic [HALF-1:0] s1_b;
  logic            s1_sgn;
  logic            s1_sub;

  logic [HALF-1:0]  hi_s;
  logic             hi_c;
  logic             hi_cmsb;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   res_d;
  logic             ov_d;

  assign adv2     = ~out_valid | out_ready;
  assign adv1     = ~s1_valid | adv2;
  assign in_ready = adv1;

  assign b_eff = (op_sub == OP_SUB) ? ~b : b;

  cla_add_n #(.N(HALF)) u_lo (
    .a    (a[HALF-1:0]),
    .b    (b_eff[HALF-1:0]),
    .cin  (op_sub),
    .s    (lo_s),
    .cout (lo_c),
    .cmsb (unused_lo_cmsb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      s1_valid <= 1'b0;
    else if (adv1)
      s1_valid <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (adv1 && in_valid) begin
      s1_lo  <= lo_s;
      s1_c   <= lo_c;
      s1_a   <= a[WIDTH-1:HALF];
      s1_b   <= b_eff[WIDTH-1:HALF];
      s1_sgn <= op_signed;
      s1_sub <= op_sub;
    end
  end

  cla_add_n #(.N(HALF)) u_hi (
    .a    (s1_a),
    .b    (s1_b),
    .cin  (s1_c),
    .s    (hi_s),
    .cout (hi_c),
    .cmsb (hi_cmsb)
  );

  assign sum = {hi_s, s1_lo};

  // bit WIDTH makes the result exact in every mode
  always_comb begin
    res_d = {1'b0, sum};
    ov_d  = 1'b0;
    unique case (1'b1)
      (s1_sgn == MODE_SGN): begin
        ov_d  = hi_c ^ hi_cmsb;
        res_d = {ov_d ? ~sum[WIDTH-1] : sum[WIDTH-1], sum};
      end
      (s1_sgn != MODE_SGN) && (s1_sub == OP_SUB): begin
        ov_d  = ~hi_c;
        res_d = {~hi_c, sum};
      end
      default: begin
        ov_d  = hi_c;
        res_d = {hi_c, sum};
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
    end else if (adv2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        result   <= res_d;
        overflow <= ov_d;
      end
    end
  end

endmodule

// File: tb/tb_add_tc_pipe.sv
// tb_add_tc_pipe: directed and random checks of the
// pipelined adder/subtractor at WIDTH=16.
module tb_add_tc_pipe;
  import add_tc_pkg::*;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  add_tc_pipe_if #(.WIDTH(W)) bus ();

  add_tc_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .a         (bus.a),
    .b         (bus.b),
    .op_sub    (bus.op_sub),
    .op_signed (bus.op_signed),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .result    (bus.result),
    .overflow  (bus.overflow)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [W-1:0] a,
                       input logic [W-1:0] b,
                       input logic sub,
                       input logic sgn);
    bus.in_valid  = 1'b1;
    bus.a         = a;
    bus.b         = b;
    bus.op_sub    = sub;
    bus.op_signed = sgn;
  endtask

  // exact-value reference: {overflow, result[16:0]}
  function automatic logic [17:0] mdl(
      input logic [W-1:0] a,
      input logic [W-1:0] b,
      input logic sub,
      input logic sgn);
    int ia, ib, t;
    logic [31:0] tv;
    logic ov;
    ia = sgn ? int'({{16{a[15]}}, a}) : int'({16'h0, a});
    ib = sgn ? int'({{16{b[15]}}, b}) : int'({16'h0, b});
    t  = sub ? ia - ib : ia + ib;
    if (sgn) ov = (t > 32767) || (t < -32768);
    else     ov = (t > 65535) || (t < 0);
    tv = t;
    return {ov, tv[16:0]};
  endfunction

  task automatic send_one(input string tag,
                          input logic [W-1:0] a,
                          input logic [W-1:0] b,
                          input logic sub,
                          input logic sgn,
                          input logic [16:0] er,
                          input logic eo);
    drive(a, b, sub, sgn);
    step();
    bus.in_valid = 1'b0;
    chk({tag, "_lat1"}, 32'(bus.out_valid), 32'd0);
    step();
    chk({tag, "_res"},
        {bus.out_valid, bus.overflow, bus.result},
        {1'b1, eo, er});
    step();
  endtask

  logic [15:0] bp_a [4] = '{16'h0001, 16'h0005,
                            16'h8000, 16'h4000};
  logic [15:0] bp_b [4] = '{16'h0002, 16'h0007,
                            16'h8000, 16'h4000};
  logic        bp_s [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  logic        bp_g [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [17:0] bp_e [4] = '{{1'b0, 17'h00003},
                            {1'b0, 17'h1FFFE},
                            {1'b1, 17'h10000},
                            {1'b1, 17'h08000}};

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int sent, got;
    logic in_fire, out_fire, stall;
    logic [17:0] held;
    logic [17:0] q [$];
    logic [17:0] e;
    logic [W-1:0] ra, rb;
    logic rs, rg;

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.op_sub    = OP_ADD;
    bus.op_signed = MODE_UNS;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    send_one("s_add_ovf", 16'h7FFF, 16'h0001,
             OP_ADD, MODE_SGN, 17'h08000, 1'b1);
    send_one("s_sub_ovf", 16'h8000, 16'h0001,
             OP_SUB, MODE_SGN, 17'h17FFF, 1'b1);
    send_one("s_add_m1p1", 16'hFFFF, 16'h0001,
             OP_ADD, MODE_SGN, 17'h00000, 1'b0);
    send_one("u_add_carry", 16'hFFFF, 16'h0001,
             OP_ADD, MODE_UNS, 17'h10000, 1'b1);
    send_one("u_sub_borrow", 16'h0003, 16'h0005,
             OP_SUB, MODE_UNS, 17'h1FFFE, 1'b1);
    send_one("u_sub_zero", 16'h1234, 16'h0000,
             OP_SUB, MODE_UNS, 17'h01234, 1'b0);
    send_one("s_add_minneg", 16'h8000, 16'h8000,
             OP_ADD, MODE_SGN, 17'h10000, 1'b1);

    sent = 0;
    got  = 0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      bus.out_ready = (c >= 3);
      if (sent < 4)
        drive(bp_a[sent], bp_b[sent], bp_s[sent], bp_g[sent]);
      else
        bus.in_valid = 1'b0;
      #1;
      if (c == 2)
        chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
      in_fire  = bus.in_valid && bus.in_ready;
      out_fire = bus.out_valid && bus.out_ready;
      stall    = bus.out_valid && !bus.out_ready;
      held     = {bus.overflow, bus.result};
      if (out_fire) begin
        chk("bp_order", {bus.overflow, bus.result}, bp_e[got]);
        got++;
      end
      step();
      if (in_fire) sent++;
      if (stall)
        chk("bp_hold",
            {bus.out_valid, bus.overflow, bus.result},
            {1'b1, held});
    end
    chk("bp_sent", sent, 4);
    chk("bp_got", got, 4);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    chk("bp_no_dup", 32'(bus.out_valid), 32'd0);

    for (int c = 0; c < 101; c++) begin
      if (c < 100) begin
        ra = W'($urandom);
        rb = W'($urandom);
        rs = 1'($urandom);
        rg = 1'($urandom);
        drive(ra, rb, rs, rg);
        q.push_back(mdl(ra, rb, rs, rg));
      end else begin
        bus.in_valid = 1'b0;
      end
      step();
      if (c >= 1) begin
        e = (q.size() > 0) ? q.pop_front() : 18'h0;
        chk("rand", {bus.out_valid, bus.overflow, bus.result},
            {1'b1, e});
      end
    end
    step();
    chk("rand_drain", 32'(bus.out_valid), 32'd0);

    drive(16'h1234, 16'h1111, OP_ADD, MODE_UNS);
    step();
    drive(16'h0F00, 16'h00F0, OP_ADD, MODE_UNS);
    step();
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_clear",
        {bus.out_valid, bus.overflow, bus.result}, 32'd0);
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("arst_stale", 32'(bus.out_valid), 32'd0);
    end
    send_one("post_rst", 16'h0003, 16'h0005,
             OP_SUB, MODE_SGN, 17'h1FFFE, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/add_tc_pipe.md
Name: add_tc_pipe

Overview:
- Parametrised, 2-stage pipelined carry-lookahead adder/subtractor.
- Successor to the fixed 16-bit two's-complement adder. Adds a width parameter, subtract mode, a signed/unsigned mode, an overflow flag and valid/ready flow control.
- Sits between operand-fetch and writeback in the datapath. Results are registered and can be back-pressured.

Parameters:
- WIDTH, 16: operand width. Must be a multiple of 8, so each half is a whole number of 4-bit lookahead groups.
- HALF, WIDTH/2: derived; bits computed per stage.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block accepts a beat this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- op_sub  input  1  1: A-B; 0: A+B
- op_signed  input  1  1: two's-complement operands; 0: unsigned
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  WIDTH+1  exact result, see arithmetic rules
- overflow  output  1  true result does not fit in WIDTH bits

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst_n).
  - rst_n low clears s1_valid, s2_valid, out_valid, result and overflow to 0 immediately, without waiting for a clock edge.
  - Beats in flight are discarded; nothing emerges after release.
  - Data registers other than the outputs are don't-care in reset.
- Handshake: a beat transfers when valid && ready on the same edge. Inputs are sampled only on an input transfer.
- Arithmetic:
  - b_eff = op_sub ? ~b : b.
  - cin = op_sub.
  - Raw sum s[WIDTH-1:0] = a + b_eff + cin, computed with p = a^b_eff, g = a&b_eff in 4-bit lookahead groups.
  - Carries: cout = carry out of the MSB; cmsb = carry into the MSB.
- Result encoding:
  - Signed: overflow = cout ^ cmsb. result[WIDTH] = overflow ? ~s[WIDTH-1] : s[WIDTH-1] (exact sign-extended value). result[WIDTH-1:0] = s.
  - Unsigned add: result = {cout, s}; overflow = cout.
  - Unsigned sub: result = {~cout, s}, where bit WIDTH is the borrow, i.e. a<b; overflow = ~cout.
- Pipeline:
  - Stage 1 computes the low HALF bits and registers them together with the low carry, the upper operand halves, op_signed and op_sub.
  - Stage 2 computes the upper half using the registered carry, then forms result and overflow into the output register.
  - No combinational path from a/b to result.
- Latency and throughput: exactly 2 cycles from input transfer to out_valid when out_ready is held high. Throughput is 1 beat per cycle.
- Flow control:
  - adv2 = ~out_valid | out_ready.
  - adv1 = ~s1_valid | adv2.
  - in_ready = adv1. This is combinational from out_ready; no path from in_valid.
- Stall: with out_ready low, result, overflow and out_valid hold stable. The pipeline holds at most 2 beats, after which in_ready goes low. Order is always preserved.
- Simultaneous events: an input transfer and an output transfer on the same edge are both honoured with no bubble.
- Boundaries:
  - op_sub with b = 0 gives cin=1, cout=1, so unsigned a-0 has borrow 0.
  - Signed a = b = most-negative add gives overflow=1 and result = -2^WIDTH.

Decomposition:
- Package add_tc_pkg holds:
  - constant GRP = 4 (lookahead group width);
  - encoding constants OP_ADD=0, OP_SUB=1, MODE_UNS=0, MODE_SGN=1.
- One sub-module, cla_add_n (parameter N, multiple of GRP):
  - inputs a, b, cin; outputs s, cout, cmsb;
  - a two-level group carry-lookahead adder.
  - Instantiated once per stage with N=HALF. The cmsb output is used only from the upper instance.

Test Plan (WIDTH=16, out_ready=1 unless stated):
- Signed add 0x7FFF+0x0001 -> 2 cycles later result=17'h08000, overflow=1.
- Signed sub 0x8000-0x0001 -> result=17'h17FFF (-32769), overflow=1. Signed add 0xFFFF+0x0001 -> result=17'h00000, overflow=0.
- Unsigned add 0xFFFF+0x0001 -> result=17'h10000, overflow=1. Unsigned sub 0x0003-0x0005 -> result=17'h1FFFE, overflow=1. Unsigned sub 0x1234-0x0000 -> result=17'h01234, overflow=0.
- Back-pressure: send 4 back-to-back beats with out_ready low for 3 cycles.
  - in_ready drops after 2 beats are accepted.
  - result holds stable while stalled.
  - All 4 results emerge in order with no loss or duplication.
- Full throughput: 100 random beats with random op_sub/op_signed and continuous valid/ready -> one result per cycle, each matching the reference model.
- Reset mid-operation: pull rst_n low asynchronously between edges with 2 beats in flight.
  - out_valid, result and overflow go to 0 immediately.
  - After release, no stale beat appears and the next accepted beat completes in 2 cycles.
